// File: rtl/nv_cdc_hs_rx.sv
// Receive side of a 4-phase req/ack handshake crossing: captures the source bus on request,
// hands it out on valid/ready, then returns ack until the source releases req.
module nv_cdc_hs_rx #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             req_sync,
    input  logic [DW-1:0]    src_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             ack,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               valid_q, valid_nxt;
    logic               ack_q, ack_nxt;
    logic               err_q, err_nxt;
    logic [DW-1:0]      data_q, data_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            valid_q <= valid_nxt;
            ack_q   <= ack_nxt;
            err_q   <= err_nxt;
            data_q  <= data_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        ack_nxt   = ack_q;
        data_nxt  = data_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_clr ? 1'b0 : err_q;
        case (state)
            IDLE: begin
                if (req_sync) begin
                    data_nxt  = src_data;
                    valid_nxt = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                // Source dropped req before we acked; still deliver, but flag it (set beats clear).
                if (!req_sync) begin
                    err_nxt = 1'b1;
                end
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = cnt_q + 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req_sync) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_nv_cdc_hs_rx.sv
// Directed bench for nv_cdc_hs_rx: a transaction-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_nv_cdc_hs_rx;

    localparam int DW    = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req;
    logic [DW-1:0]    src;
    logic             out_valid;
    logic             ready;
    logic [DW-1:0]    out_data;
    logic             ack;
    logic             err;
    logic             err_clr;
    logic [CNT_W-1:0] xfer_cnt;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    nv_cdc_hs_rx #(.DW(DW), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .req_sync       (req),
        .src_data       (src),
        .out_valid      (out_valid),
        .out_ready      (ready),
        .out_data       (out_data),
        .ack            (ack),
        .err            (err),
        .err_clr        (err_clr),
        .xfer_cnt       (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: a word is either held for the consumer, being acknowledged, or absent.
    logic          m_holding, m_acking, m_err;
    logic [DW-1:0] m_data;
    int            m_done;

    always @(posedge clk) begin
        if (!rstn) begin
            m_holding <= 1'b0;
            m_acking  <= 1'b0;
            m_err     <= 1'b0;
            m_data    <= '0;
            m_done    <= 0;
        end else begin
            if (m_holding) begin
                if (ready) begin
                    m_holding <= 1'b0;
                    m_acking  <= 1'b1;
                    m_done    <= (m_done + 1) % (1 << CNT_W);
                end
            end else if (m_acking) begin
                if (!req) m_acking <= 1'b0;
            end else if (req) begin
                m_holding <= 1'b1;
                m_data    <= src;
            end
            m_err <= (m_holding && !req) ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("model_out_valid", out_valid, m_holding);
            chk("model_ack", ack, m_acking);
            chk("model_err", err, m_err);
            chk("model_out_data", out_data, m_data);
            chk("model_xfer_cnt", xfer_cnt, m_done[CNT_W-1:0]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && out_valid !== 1'b1; i++) @(negedge clk);
        chk("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic wait_ack(input logic lvl, input int budget);
        for (int i = 0; i < budget && ack !== lvl; i++) @(negedge clk);
        chk("wait_ack", ack, lvl);
    endtask

    initial begin
        rstn    = 1'b0;
        req     = 1'b0;
        ready   = 1'b0;
        err_clr = 1'b0;
        src     = '0;
        cyc(2);
        mon_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        rstn = 1'b1;
        cyc(1);

        // T1 basic
        src = 32'hDEADBEEF; ready = 1'b1; req = 1'b1;
        cyc(1);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'hDEADBEEF);
        cyc(1);
        chk("t1_ack", ack, 1);
        chk("t1_valid_drop", out_valid, 0);
        req = 1'b0;
        cyc(1);
        chk("t1_ack_drop", ack, 0);
        chk("t1_cnt", xfer_cnt, 1);
        cyc(1);

        // T2 backpressure
        ready = 1'b0; req = 1'b1;
        cyc(1);
        chk("t2_valid", out_valid, 1);
        src = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_data", out_data, 32'hDEADBEEF);
            chk("t2_hold_ack", ack, 0);
        end
        ready = 1'b1;
        cyc(1);
        chk("t2_ack", ack, 1);
        chk("t2_cnt", xfer_cnt, 2);
        req = 1'b0;
        cyc(2);

        // T3 early drop
        ready = 1'b0; src = 32'hCAFE0003; req = 1'b1;
        cyc(1);
        chk("t3_valid", out_valid, 1);
        chk("t3_err_pre", err, 0);
        req = 1'b0;
        cyc(1);
        chk("t3_err", err, 1);
        chk("t3_still_valid", out_valid, 1);
        chk("t3_data", out_data, 32'hCAFE0003);
        ready = 1'b1;
        cyc(1);
        chk("t3_ack", ack, 1);
        chk("t3_cnt", xfer_cnt, 3);
        cyc(1);
        chk("t3_ack_pulse", ack, 0);
        chk("t3_err_sticky", err, 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t3_err_clr", err, 0);

        // T4 clear/set race
        ready = 1'b0; src = 32'h00000044; req = 1'b1;
        cyc(1);
        chk("t4_valid", out_valid, 1);
        req = 1'b0; err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t4_set_wins", err, 1);
        ready = 1'b1;
        cyc(1);
        chk("t4_cnt", xfer_cnt, 4);
        cyc(1);
        chk("t4_idle_ack", ack, 0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t4_err_clr", err, 0);

        // T5 wrap with CNT_W=4
        rstn = 1'b0;
        cyc(1);
        rstn = 1'b1;
        chk("t5_cnt_start", xfer_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            src = DW'(i); req = 1'b1;
            wait_valid(4);
            chk("t5_data", out_data, i);
            wait_ack(1'b1, 4);
            req = 1'b0;
            wait_ack(1'b0, 4);
            chk("t5_cnt", xfer_cnt, (i + 1) % 16);
            cyc(1);
        end
        chk("t5_cnt_wrap", xfer_cnt, 0);

        // T6 reset mid-ACK
        src = 32'h00000066; req = 1'b1;
        wait_valid(4);
        wait_ack(1'b1, 4);
        rstn = 1'b0;
        cyc(1);
        rstn = 1'b1;
        chk("t6_ack", ack, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_cnt", xfer_cnt, 0);
        cyc(1);
        chk("t6_recapture", out_valid, 1);
        chk("t6_data", out_data, 32'h00000066);
        wait_ack(1'b1, 4);
        req = 1'b0;
        wait_ack(1'b0, 4);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
